// File: rtl/sync_fifo_module_2_pkg.sv
// Shared defaults and the access-type encoding used by the FIFO control logic.
package sync_fifo_module_2_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefAddrW = 2;
  localparam int unsigned DefLeftW = 3;

  typedef enum logic [1:0] {
    OpIdle  = 2'b00,
    OpRead  = 2'b01,
    OpWrite = 2'b10,
    OpBoth  = 2'b11
  } op_e;

endpackage

// File: rtl/sync_fifo_module_2_ctrl.sv
// Pointer and occupancy control for the FIFO; strobes are qualified on the pre-edge count.
module sync_fifo_module_2_ctrl
  import sync_fifo_module_2_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LEFT_W = DefLeftW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_req,
  input  logic              read_req,
  output logic              o_wr_en,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_wr_ptr,
  output logic [ADDR_W-1:0] o_rd_ptr,
  output logic [LEFT_W-1:0] o_left
);

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LEFT_W-1:0] r_count, r_left;
  logic [LEFT_W-1:0] w_count_d, w_left_d;
  op_e               w_op;

  assign o_wr_en = write_req & (r_count != LEFT_W'(DEPTH));
  assign o_rd_en = read_req & (r_count != '0);
  assign w_op    = op_e'({o_wr_en, o_rd_en});

  // Free-space count is kept in its own register so left_sig has no input-to-output path.
  always_comb begin
    w_count_d = r_count;
    w_left_d  = r_left;
    unique case (w_op)
      OpWrite: begin
        w_count_d = r_count + LEFT_W'(1);
        w_left_d  = r_left - LEFT_W'(1);
      end
      OpRead: begin
        w_count_d = r_count - LEFT_W'(1);
        w_left_d  = r_left + LEFT_W'(1);
      end
      OpIdle, OpBoth: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_left   <= LEFT_W'(DEPTH);
    end else begin
      if (o_wr_en) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (o_rd_en) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_count <= w_count_d;
      r_left  <= w_left_d;
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_left   = r_left;

endmodule

// File: rtl/sync_fifo_module_2.sv
// Single-clock FIFO with registered read data and a registered free-space count.
module sync_fifo_module_2
  import sync_fifo_module_2_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LEFT_W = DefLeftW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_req,
  input  logic [DATA_W-1:0] FIFO_write_data,
  input  logic              read_req,
  output logic [DATA_W-1:0] FIFO_read_data,
  output logic [LEFT_W-1:0] left_sig
);

  logic              w_wr_en, w_rd_en;
  logic [ADDR_W-1:0] w_wr_ptr, w_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  sync_fifo_module_2_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LEFT_W (LEFT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .write_req (write_req),
    .read_req  (read_req),
    .o_wr_en   (w_wr_en),
    .o_rd_en   (w_rd_en),
    .o_wr_ptr  (w_wr_ptr),
    .o_rd_ptr  (w_rd_ptr),
    .o_left    (left_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_wr_ptr] <= FIFO_write_data;
    end
  end

  // No bypass: a read on an empty FIFO is rejected, so data never comes straight from the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (w_rd_en) begin
      r_rd_data <= r_mem[w_rd_ptr];
    end
  end

  assign FIFO_read_data = r_rd_data;

endmodule

// File: tb/tb_sync_fifo_module_2.sv
// Directed and randomized checks of the FIFO against a queue-based reference model.
module tb_sync_fifo_module_2;

  localparam int Depth = 4;

  logic       clk;
  logic       rst_n;
  logic       write_req;
  logic [7:0] FIFO_write_data;
  logic       read_req;
  logic [7:0] FIFO_read_data;
  logic [2:0] left_sig;

  int         checks;
  int         errors;
  logic [7:0] q[$];
  logic [7:0] exp_data;

  sync_fifo_module_2 dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .write_req       (write_req),
    .FIFO_write_data (FIFO_write_data),
    .read_req        (read_req),
    .FIFO_read_data  (FIFO_read_data),
    .left_sig        (left_sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model updates from the pre-edge occupancy, like the hardware.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input string tag);
    logic wr_ok, rd_ok;
    @(negedge clk);
    write_req       = wr;
    FIFO_write_data = d;
    read_req        = rd;
    @(posedge clk);
    wr_ok = wr && (q.size() != Depth);
    rd_ok = rd && (q.size() != 0);
    if (rd_ok) exp_data = q.pop_front();
    if (wr_ok) q.push_back(d);
    #1;
    check({tag, "_data"}, 32'(FIFO_read_data), 32'(exp_data));
    check({tag, "_left"}, 32'(left_sig), 32'(Depth - q.size()));
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    exp_data        = 8'h00;
    rst_n           = 1'b0;
    write_req       = 1'b0;
    read_req        = 1'b0;
    FIFO_write_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_data", 32'(FIFO_read_data), 32'h0);
    check("reset_left", 32'(left_sig), 32'd4);

    // Fill, then overflow attempt
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, "fill");
    step(1'b1, 8'd9, 1'b0, "full_write");

    // Drain, then underflow attempt
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, "drain");
    step(1'b0, 8'h00, 1'b1, "empty_read");

    // Wrap with simultaneous read and write
    step(1'b1, 8'd5, 1'b0, "wrap_w");
    step(1'b1, 8'd6, 1'b0, "wrap_w");
    step(1'b1, 8'd7, 1'b1, "overlap");
    step(1'b1, 8'd8, 1'b1, "overlap");
    step(1'b0, 8'h00, 1'b1, "wrap_r");
    step(1'b0, 8'h00, 1'b1, "wrap_r");

    // Boundaries with both strobes: full accepts only the read, empty only the write
    step(1'b1, 8'h21, 1'b1, "empty_both");
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, "refill");
    step(1'b1, 8'h99, 1'b1, "full_both");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, "drain2");

    // Asynchronous reset between edges
    step(1'b1, 8'd1, 1'b0, "pre_rst");
    step(1'b1, 8'd2, 1'b1, "pre_rst");
    @(negedge clk);
    write_req = 1'b0;
    read_req  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(FIFO_read_data), 32'h0);
    check("async_rst_left", 32'(left_sig), 32'd4);
    q.delete();
    exp_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'hab, 1'b0, "post_rst");
    step(1'b0, 8'h00, 1'b1, "post_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    @(negedge clk);
    write_req = 1'b0;
    read_req  = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
